spi_cfg_regs: RTL and testbench

- SPI-slave configuration block that programs the PWM peripheral's control registers from off-chip.
- Sits in the top level between the SPI pins (sclk, copi, ncs on dedicated inputs) and pwm_peripheral.
- Drives en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle.
- All SPI pins are asynchronous to clk; they are synchronised and oversampled in the clk domain.

---
 rtl/spi_cfg_regs_if.sv | 10 +
 rtl/spi_cfg_regs.sv | 177 +++++++++++++++++
 tb/tb_spi_cfg_regs.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_regs_if.sv
// SPI pin bundle between an off-chip master and the spi_cfg_regs slave.
interface spi_cfg_regs_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (output sclk, output copi, output ncs, input cipo);
    modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_cfg_regs.sv
// SPI-slave (mode 0) block that programs the PWM control registers from off-chip.
// Define SPI_READBACK_EN to return register contents on cipo for read frames.
module spi_cfg_regs #(
    parameter int unsigned SYNC_STAGES = 2,      // synchroniser depth, must be >= 2
    parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_cfg_regs_if.slave spi,
    output logic [7:0]    en_reg_out_7_0,
    output logic [7:0]    en_reg_out_15_8,
    output logic [7:0]    en_reg_pwm_7_0,
    output logic [7:0]    en_reg_pwm_15_8,
    output logic [7:0]    pwm_duty_cycle,
    output logic          cfg_update
);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic                   sclk_hist_q, ncs_hist_q;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_rise, ncs_fall;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] shreg_q, shreg_d;
    logic [7:0]  regs_q [5];
    logic        cfg_update_q;
    logic        commit_ok;
    logic [6:0]  addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi.copi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi.ncs};
            sclk_hist_q <= sclk_s;
            ncs_hist_q  <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign ncs_rise  = ncs_s & ~ncs_hist_q;
    assign ncs_fall  = ~ncs_s & ncs_hist_q;
    assign addr      = shreg_q[14:8];

    // Counter saturates at 17 so any frame longer than 16 bits is recognisably invalid.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        commit_ok = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ncs_fall) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            StShift: begin
                if (ncs_rise) begin
                    state_d = StCommit;
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[14:0], copi_s};
                    if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
                end
            end
            StCommit: begin
                commit_ok = (cnt_q == 5'd16) && shreg_q[15] && (addr <= MAX_ADDR);
                if (ncs_fall) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) regs_q[i] <= '0;
            cfg_update_q <= 1'b0;
        end else begin
            cfg_update_q <= commit_ok;
            if (commit_ok) begin
                case (addr)
                    7'h00:   regs_q[0] <= shreg_q[7:0];
                    7'h01:   regs_q[1] <= shreg_q[7:0];
                    7'h02:   regs_q[2] <= shreg_q[7:0];
                    7'h03:   regs_q[3] <= shreg_q[7:0];
                    7'h04:   regs_q[4] <= shreg_q[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign cfg_update      = cfg_update_q;

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [7:0] rd_sel;
    logic [7:0] rd_q;
    logic       cipo_q;

    assign sclk_fall = ~sclk_s & sclk_hist_q;

    // After 8 bits the shift register holds {rw, addr}, so the address is shreg_q[6:0] here.
    always_comb begin
        rd_sel = 8'h00;
        if (shreg_q[6:0] <= MAX_ADDR) begin
            case (shreg_q[6:0])
                7'h00:   rd_sel = regs_q[0];
                7'h01:   rd_sel = regs_q[1];
                7'h02:   rd_sel = regs_q[2];
                7'h03:   rd_sel = regs_q[3];
                7'h04:   rd_sel = regs_q[4];
                default: rd_sel = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q   <= '0;
            cipo_q <= 1'b0;
        end else if (state_q != StShift || ncs_rise) begin
            rd_q   <= '0;
            cipo_q <= 1'b0;
        end else if (sclk_fall) begin
            if (cnt_q == 5'd8 && !shreg_q[7]) begin
                cipo_q <= rd_sel[7];
                rd_q   <= {rd_sel[6:0], 1'b0};
            end else begin
                cipo_q <= rd_q[7];
                rd_q   <= {rd_q[6:0], 1'b0};
            end
        end
    end

    assign spi.cipo = cipo_q;
`else
    assign spi.cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cfg_regs.sv
// Self-checking bench for spi_cfg_regs: directed scenarios plus randomized frames
// checked against a register-array model.
module tb_spi_cfg_regs;
    localparam int HALF = 5;  // sclk half period in clk cycles

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] r0, r1, r2, r3, r4;
    logic cfg_update;

    always #5 clk = ~clk;

    spi_cfg_regs_if spi_bus ();

    spi_cfg_regs #(
        .SYNC_STAGES (2),
        .MAX_ADDR    (7'h04)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (spi_bus),
        .en_reg_out_7_0  (r0),
        .en_reg_out_15_8 (r1),
        .en_reg_pwm_7_0  (r2),
        .en_reg_pwm_15_8 (r3),
        .pwm_duty_cycle  (r4),
        .cfg_update      (cfg_update)
    );

    int n_checks = 0;
    int n_fail = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic prev_upd = 1'b0;
    bit wide = 1'b0;
    logic [7:0] model [5];

    always @(negedge clk) begin
        if (cfg_update === 1'b1) begin
            pulses++;
            if (prev_upd === 1'b1) wide = 1'b1;
        end
        prev_upd = cfg_update;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [39:0] model_vec();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // Spec-level effect of one complete frame as seen by the register file.
    task automatic model_frame(input logic [15:0] w, input int n);
        if (n == 16 && w[15] && w[14:8] <= 7'h04) begin
            model[int'(w[10:8])] = w[7:0];
            exp_pulses++;
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 5; a++) model[a] = 8'h00;
    endtask

    // Drives one frame MSB first; bits beyond 16 are random. Checks cipo before each rise.
    task automatic spi_frame(input string tag, input logic [15:0] word, input int nbits,
                             input int rst_at, input int gap);
        logic exp_c;
`ifdef SPI_READBACK_EN
        logic [7:0] rb;
        rb = (word[14:8] <= 7'h04) ? model[int'(word[10:8])] : 8'h00;
`endif
        spi_bus.ncs = 1'b0;
        wait_clks(6);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                wait_clks(2);
                rst_n = 1'b1;
                wait_clks(2);
            end
            spi_bus.copi = (i < 16) ? word[15-i] : 1'($urandom_range(0, 1));
            wait_clks(HALF);
            if (i < 16) begin
                exp_c = 1'b0;
`ifdef SPI_READBACK_EN
                if (!word[15] && i >= 8) exp_c = rb[15-i];
`endif
                n_checks++;
                if (spi_bus.cipo !== exp_c) begin
                    n_fail++;
                    $display("FAIL %s cipo bit%0d: got %b expected %b", tag, i, spi_bus.cipo, exp_c);
                end
            end
            spi_bus.sclk = 1'b1;
            wait_clks(HALF);
            spi_bus.sclk = 1'b0;
        end
        wait_clks(HALF);
        spi_bus.ncs = 1'b1;
        wait_clks(gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        spi_bus.sclk = 1'b0;
        spi_bus.copi = 1'b0;
        spi_bus.ncs = 1'b1;
        model_reset();
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(4);
        n_checks++;
        if ({r4, r3, r2, r1, r0} !== model_vec()) begin
            n_fail++;
            $display("FAIL reset regs: got %h expected %h", {r4, r3, r2, r1, r0}, model_vec());
        end
        n_checks++;
        if (cfg_update !== 1'b0) begin
            n_fail++;
            $display("FAIL reset cfg_update: got %b expected 0", cfg_update);
        end
        n_checks++;
        if (spi_bus.cipo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset cipo: got %b expected 0", spi_bus.cipo);
        end
    endtask

    task automatic test_write_basic();
        spi_frame("wr_basic", 16'h80F0, 16, -1, 10);
        model_frame(16'h80F0, 16);
        n_checks++;
        if ({r4, r3, r2, r1, r0} !== model_vec()) begin
            n_fail++;
            $display("FAIL wr_basic regs: got %h expected %h", {r4, r3, r2, r1, r0}, model_vec());
        end
        n_checks++;
        if (pulses !== exp_pulses) begin
            n_fail++;
            $display("FAIL wr_basic pulses: got %0d expected %0d", pulses, exp_pulses);
        end
    endtask

    task automatic test_two_writes();
        spi_frame("wr_two_a", 16'h8480, 16, -1, 10);
        model_frame(16'h8480, 16);
        spi_frame("wr_two_b", 16'h8201, 16, -1, 10);
        model_frame(16'h8201, 16);
        n_checks++;
        if ({r4, r2} !== 16'h8001 || {r4, r3, r2, r1, r0} !== model_vec()) begin
            n_fail++;
            $display("FAIL wr_two regs: got %h expected %h", {r4, r3, r2, r1, r0}, model_vec());
        end
        n_checks++;
        if (pulses !== exp_pulses) begin
            n_fail++;
            $display("FAIL wr_two pulses: got %0d expected %0d", pulses, exp_pulses);
        end
    endtask

    task automatic test_dropped();
        spi_frame("drop_addr", 16'h85FF, 16, -1, 10);
        model_frame(16'h85FF, 16);
        spi_frame("drop_read", 16'h0155, 16, -1, 10);
        model_frame(16'h0155, 16);
        n_checks++;
        if ({r4, r3, r2, r1, r0} !== model_vec()) begin
            n_fail++;
            $display("FAIL dropped regs: got %h expected %h", {r4, r3, r2, r1, r0}, model_vec());
        end
        n_checks++;
        if (pulses !== exp_pulses) begin
            n_fail++;
            $display("FAIL dropped pulses: got %0d expected %0d", pulses, exp_pulses);
        end
    endtask

    task automatic test_short_long();
        spi_frame("short", 16'h81AA, 12, -1, 10);
        model_frame(16'h81AA, 12);
        spi_frame("long", 16'h81AA, 20, -1, 10);
        model_frame(16'h81AA, 20);
        n_checks++;
        if ({r4, r3, r2, r1, r0} !== model_vec()) begin
            n_fail++;
            $display("FAIL short_long regs: got %h expected %h", {r4, r3, r2, r1, r0}, model_vec());
        end
        n_checks++;
        if (pulses !== exp_pulses) begin
            n_fail++;
            $display("FAIL short_long pulses: got %0d expected %0d", pulses, exp_pulses);
        end
    endtask

    task automatic test_reset_mid_frame();
        spi_frame("pre_rst", 16'h8177, 16, -1, 10);
        model_frame(16'h8177, 16);
        spi_frame("mid_rst", 16'h8133, 16, 9, 10);
        model_reset();
        n_checks++;
        if ({r4, r3, r2, r1, r0} !== model_vec()) begin
            n_fail++;
            $display("FAIL mid_rst regs: got %h expected %h", {r4, r3, r2, r1, r0}, model_vec());
        end
        n_checks++;
        if (pulses !== exp_pulses) begin
            n_fail++;
            $display("FAIL mid_rst pulses: got %0d expected %0d", pulses, exp_pulses);
        end
    endtask

    // ncs is high for a single clk, so the next frame starts while the commit is in flight.
    task automatic test_back_to_back();
        spi_frame("b2b_a", 16'h8311, 16, -1, 1);
        model_frame(16'h8311, 16);
        spi_frame("b2b_b", 16'h8422, 16, -1, 10);
        model_frame(16'h8422, 16);
        n_checks++;
        if ({r4, r3, r2, r1, r0} !== model_vec()) begin
            n_fail++;
            $display("FAIL b2b regs: got %h expected %h", {r4, r3, r2, r1, r0}, model_vec());
        end
        n_checks++;
        if (pulses !== exp_pulses) begin
            n_fail++;
            $display("FAIL b2b pulses: got %0d expected %0d", pulses, exp_pulses);
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        int n;
        int sel;
        for (int f = 0; f < 24; f++) begin
            w = {($urandom_range(0, 3) != 0), 7'($urandom_range(0, 9)), 8'($urandom)};
            sel = $urandom_range(0, 5);
            n = (sel == 0) ? $urandom_range(1, 15) : (sel == 1) ? $urandom_range(17, 20) : 16;
            spi_frame("rand", w, n, -1, ($urandom_range(0, 3) == 0) ? 1 : 10);
            if (n == 16 && w[15] == 1'b0) begin
                // keep the model's view: read frames never write
            end
            model_frame(w, n);
            wait_clks(10);
            n_checks++;
            if ({r4, r3, r2, r1, r0} !== model_vec()) begin
                n_fail++;
                $display("FAIL rand%0d regs (w=%h n=%0d): got %h expected %h", f, w, n,
                         {r4, r3, r2, r1, r0}, model_vec());
            end
            n_checks++;
            if (pulses !== exp_pulses) begin
                n_fail++;
                $display("FAIL rand%0d pulses: got %0d expected %0d", f, pulses, exp_pulses);
            end
        end
        n_checks++;
        if (wide !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_width: got multi-cycle cfg_update expected single-cycle");
        end
    endtask

`ifdef SPI_READBACK_EN
    task automatic test_readback();
        spi_frame("rb_wr", 16'h83A5, 16, -1, 10);
        model_frame(16'h83A5, 16);
        spi_frame("rb_rd", 16'h0300, 16, -1, 10);
        model_frame(16'h0300, 16);
        n_checks++;
        if ({r4, r3, r2, r1, r0} !== model_vec()) begin
            n_fail++;
            $display("FAIL readback regs: got %h expected %h", {r4, r3, r2, r1, r0}, model_vec());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_two_writes();
        test_dropped();
        test_short_long();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef SPI_READBACK_EN
        test_readback();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
